// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared LED word geometry, colour byte offsets and fetch FSM encoding.
package ws2812b_pkg;
   localparam int BITS_PER_LED  = 24;
   localparam int BYTES_PER_LED = 3;
   localparam int G_OFS = 0;
   localparam int R_OFS = 1;
   localparam int B_OFS = 2;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;
   // Byte slot k = stripe*3 + colour; G sits in the top byte of each stripe's 24 bits.
   function automatic int byte_lsb(input int k);
      int c;
      c = k % BYTES_PER_LED;
      return (k / BYTES_PER_LED) * BITS_PER_LED + (B_OFS - c) * 8;
   endfunction
endpackage

// File: rtl/ws2812b_byte_scale.sv
// ws2812b_byte_scale: scales one colour byte by (brightness+1)/256.
module ws2812b_byte_scale (
   input  logic [7:0] data,
   input  logic [7:0] scale,
   output logic [7:0] result
);
   assign result = 8'(({8'd0, data} * ({8'd0, scale} + 16'd1)) >> 8);
endmodule

// File: rtl/ws2812b_frame_fetch.sv
// ws2812b_frame_fetch: walks the LED BRAM per frame and hands one 24*STRIPE_COUNT-bit word per LED to the serializer.
// Define WS2812B_BRIGHTNESS_EN to add the brightness port and per-byte scaling in the capture path.
module ws2812b_frame_fetch
   import ws2812b_pkg::*;
#(
   parameter int STRIPE_COUNT = 2,
   parameter int LED_COUNT    = 121,
   parameter int ADDR_WIDTH   = 14,
   parameter int BASE_ADDR    = 0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   frame_start,
   output logic [ADDR_WIDTH-1:0]                  mem_addr,
   input  logic [7:0]                             mem_data,
`ifdef WS2812B_BRIGHTNESS_EN
   input  logic [7:0]                             brightness,
`endif
   output logic [BITS_PER_LED*STRIPE_COUNT-1:0]   bitstream,
   output logic                                   bitstream_available,
   input  logic                                   bitstream_read,
   output logic                                   busy,
   output logic                                   frame_done
);
   localparam int W  = BITS_PER_LED * STRIPE_COUNT;
   localparam int NB = BYTES_PER_LED * STRIPE_COUNT;
   localparam int KW = $clog2(NB);
   localparam int LW = $clog2(LED_COUNT + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   logic [1:0]    state;
   logic [KW-1:0] iss_k, cap_k;
   logic          cap_vld, asm_full, asm_done, xfer, start, last_iss;
   logic [LW-1:0] led;
   logic [W-1:0]  asm_q, merged;
   logic [7:0]    cap_byte;

`ifdef WS2812B_BRIGHTNESS_EN
   ws2812b_byte_scale u_scale (.data(mem_data), .scale(brightness), .result(cap_byte));
`else
   assign cap_byte = mem_data;
`endif

   assign start    = state == S_IDLE && frame_start && !frame_done;
   assign last_iss = iss_k == KW'(NB - 1);
   // The final byte bypasses the assembly register so the word can load the cycle it arrives.
   assign asm_done = asm_full || (cap_vld && cap_k == KW'(NB - 1));
   assign xfer     = state == S_HOLD && asm_done && (!bitstream_available || bitstream_read);
   assign busy     = state != S_IDLE;

   for (genvar i = 0; i < NB; i++) begin : g_slot
      localparam int L = byte_lsb(i);
      assign merged[L +: 8] = cap_vld && cap_k == KW'(i) ? cap_byte : asm_q[L +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= S_IDLE;
         mem_addr            <= BASE;
         iss_k               <= '0;
         cap_k               <= '0;
         cap_vld             <= 1'b0;
         asm_full            <= 1'b0;
         asm_q               <= '0;
         led                 <= '0;
         bitstream           <= '0;
         bitstream_available <= 1'b0;
         frame_done          <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         cap_vld    <= state == S_FETCH;
         cap_k      <= iss_k;
         if (cap_vld) asm_q <= merged;
         if (bitstream_available && bitstream_read) bitstream_available <= 1'b0;
         if (xfer) begin
            bitstream           <= merged;
            bitstream_available <= 1'b1;
         end
         case (state)
            S_IDLE: if (start) begin
               state    <= S_FETCH;
               mem_addr <= BASE;
               iss_k    <= '0;
               led      <= '0;
            end
            S_FETCH: begin
               mem_addr <= mem_addr + 1'b1;
               iss_k    <= last_iss ? '0 : iss_k + 1'b1;
               if (last_iss) begin
                  led   <= led + 1'b1;
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (xfer) begin
                  asm_full <= 1'b0;
                  state    <= led == LW'(LED_COUNT) ? S_DRAIN : S_FETCH;
               end else if (asm_done) asm_full <= 1'b1;
            end
            default: if (bitstream_read) begin
               frame_done <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812b_frame_fetch.sv
// tb_ws2812b_frame_fetch: two lockstep instances (base 0 and base 16383) checked against an address-formula model.
module tb_ws2812b_frame_fetch;
   localparam int S  = 2;
   localparam int N  = 3;
   localparam int AW = 14;
   localparam int WB = 16383;

   logic          clk = 1'b0;
   logic          reset, frame_start, read;
   logic [AW-1:0] addr, waddr;
   logic [7:0]    md, wmd, brightness;
   logic [47:0]   bits, wbits;
   logic          avail, wavail, busy, wbusy, done, wdone;
   logic [7:0]    mem [0:16383];
   int            tests = 0, fails = 0, idx = 0, done_cnt = 0;
   logic          pv = 1'b0, pr = 1'b0;
   logic [47:0]   pb = '0;

   always #5 clk = ~clk;

   ws2812b_frame_fetch #(.STRIPE_COUNT(S), .LED_COUNT(N), .ADDR_WIDTH(AW), .BASE_ADDR(0)) u_dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .mem_addr(addr), .mem_data(md),
`ifdef WS2812B_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .bitstream(bits), .bitstream_available(avail), .bitstream_read(read), .busy(busy), .frame_done(done));

   ws2812b_frame_fetch #(.STRIPE_COUNT(S), .LED_COUNT(N), .ADDR_WIDTH(AW), .BASE_ADDR(WB)) u_wrap (
      .clk(clk), .reset(reset), .frame_start(frame_start), .mem_addr(waddr), .mem_data(wmd),
`ifdef WS2812B_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .bitstream(wbits), .bitstream_available(wavail), .bitstream_read(read), .busy(wbusy), .frame_done(wdone));

   always @(posedge clk) begin
      md  <= mem[addr];
      wmd <= mem[waddr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] exp_word(input int base, input int n);
      logic [47:0] w;
      logic [7:0]  b;
      w = '0;
      for (int s = 0; s < S; s++)
         for (int c = 0; c < 3; c++) begin
            b = mem[(base + (n * S + s) * 3 + c) % 16384];
`ifdef WS2812B_BRIGHTNESS_EN
            b = 8'((int'(b) * (int'(brightness) + 1)) >> 8);
`endif
            w[24 * s + 8 * (2 - c) +: 8] = b;
         end
      return w;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 500) begin
         tick();
         n++;
      end
      check(tag, done, 1);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         idx = 0;
         pv  = 1'b0;
      end else begin
         if (pv && !pr) begin
            check("hold_avail", avail, 1);
            check("hold_bits", bits, pb);
         end
         if (avail && read) begin
            check("word", bits, exp_word(0, idx));
            check("wrap_word", wbits, exp_word(WB, idx));
            check("lockstep", {wavail, wbusy, wdone}, {avail, busy, done});
            idx++;
         end
         if (done) begin
            check("done_words", idx, N);
            check("done_busy", busy, 0);
            idx = 0;
            done_cnt++;
         end
         pv = avail;
         pr = read;
         pb = bits;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int c, d0;
      reset = 1'b1; frame_start = 1'b0; read = 1'b0; brightness = 8'd255;
      for (int a = 0; a < 16384; a++) mem[a] = 8'(a);
      tick(3);
      reset = 1'b0;
      tick();
      check("rst_addr", addr, 0);
      check("rst_waddr", waddr, WB);
      check("rst_avail", avail, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bits", bits, 0);

      // Read held high: latency, first word, address wrap on the second instance.
      read = 1'b1; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("c1_addr", addr, 0);
      check("c1_waddr", waddr, WB);
      check("c1_busy", busy, 1);
      tick();
      check("c2_addr", addr, 1);
      check("c2_waddr", waddr, 0);
      c = 2;
      while (!avail && c < 40) begin tick(); c++; end
      check("latency", c, 3 * S + 2);
      check("first_word", bits, 48'h030405_000102);
      check("first_wword", wbits, 48'h020304_FF0001);
      wait_done("t1_done");
      tick(3);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_busy", busy, 0);

      // Read held low: one prefetch burst, then addresses freeze.
      read = 1'b0; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick(40);
      check("t2_addr", addr, 2 * 3 * S);
      check("t2_waddr", waddr, (WB + 2 * 3 * S) % 16384);
      check("t2_avail", avail, 1);
      check("t2_word0", bits, exp_word(0, 0));
      read = 1'b1;
      wait_done("t2_done");
      tick(2);

      // Start pulses while busy and in the frame_done cycle are ignored.
      d0 = done_cnt;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick(4);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_done("t3_done");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick(20);
      check("t3_busy", busy, 0);
      check("t3_avail", avail, 0);
      check("t3_addr", addr, N * 3 * S);
      check("t3_done_cnt", done_cnt, d0 + 1);

      // Reset while word 1 is presented, then restart.
      d0 = done_cnt;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      c = 0;
      while (!(avail && idx == 1) && c < 100) begin tick(); c++; end
      check("t4_reach", avail && idx == 1, 1);
      reset = 1'b1; read = 1'b0;
      tick();
      reset = 1'b0;
      check("t4_avail", avail, 0);
      check("t4_busy", busy, 0);
      check("t4_addr", addr, 0);
      check("t4_waddr", waddr, WB);
      check("t4_done", done, 0);
      tick(2);
      read = 1'b1; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      c = 1;
      while (!avail && c < 40) begin tick(); c++; end
      check("t4_latency", c, 3 * S + 2);
      check("t4_word0", bits, 48'h030405_000102);
      wait_done("t4_done_seen");
      tick(2);
      check("t4_done_cnt", done_cnt, d0 + 1);

      // Random BRAM contents, random read pattern, stray starts while busy.
      d0 = done_cnt;
      for (int f = 0; f < 6; f++) begin
         for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
`ifdef WS2812B_BRIGHTNESS_EN
         brightness = f == 0 ? 8'd0 : f == 1 ? 8'd127 : f == 2 ? 8'd255 : 8'($urandom);
`endif
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         c = 0;
         while (!done && c < 400) begin
            read = 1'($urandom % 2);
            frame_start = busy && ($urandom % 8 == 0);
            tick();
            c++;
         end
         frame_start = 1'b0;
         check("rnd_done", done, 1);
         tick(2);
      end
      check("rnd_done_cnt", done_cnt, d0 + 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ws2812b_frame_fetch.md
Name: ws2812b_frame_fetch

Overview:
Frame-fetch stage that sits directly upstream of the parallel WS2812B output serializer. On each frame_start it walks the SPI-filled block RAM LED by LED and reads the GRB bytes of every stripe. For each LED index it assembles one 24*STRIPE_COUNT-bit word and hands it to the serializer through the bitstream_available / bitstream_read handshake. Two-stage buffering (assembly register plus output register) prefetches LED n+1 while LED n is being shifted out.

Parameters:
STRIPE_COUNT, 2, number of parallel stripes; word width is 24*STRIPE_COUNT.
LED_COUNT, 121, LEDs per stripe (must be >= 1).
ADDR_WIDTH, 14, BRAM address width.
BASE_ADDR, 0, BRAM byte address of LED 0, stripe 0, green.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
frame_start  in  1  single-cycle pulse that starts a frame; ignored while busy.
mem_addr  out  ADDR_WIDTH  BRAM read address (registered).
mem_data  in  8  BRAM read data, valid exactly 1 cycle after mem_addr.
bitstream  out  24*STRIPE_COUNT  LED word; stripe s occupies [24s+23:24s] as G[23:16], R[15:8], B[7:0].
bitstream_available  out  1  bitstream holds a valid word.
bitstream_read  in  1  serializer has consumed the current word.
busy  out  1  high from the cycle after an accepted frame_start until frame_done.
frame_done  out  1  single-cycle pulse when the last LED word is consumed.

Behaviour:
- Reset values: mem_addr=BASE_ADDR, bitstream=0, bitstream_available=0, busy=0, frame_done=0. Reset mid-frame aborts the frame immediately and returns the FSM to IDLE. No pulse is emitted.
- Byte address formula: BASE_ADDR + (led*STRIPE_COUNT + s)*3 + c, with c = 0 for G, 1 for R, 2 for B. Computed with ADDR_WIDTH-bit wrap-around. Implemented as a running incrementer, not a multiply.
- FSM states:
  - IDLE: leave on frame_start.
  - FETCH: issue 3*STRIPE_COUNT consecutive addresses, one per cycle; capture mem_data one cycle later into byte slot k of the assembly register.
  - HOLD: assembly register full and output register still occupied.
  - DRAIN: last LED assembled; waiting for the final read.
  - Return to IDLE after the final read.
- Transfer to output: the output register loads from the assembly register in the cycle after assembly completes if the output register is empty, or if bitstream_read is high in that same cycle (zero-bubble handover). The next FETCH starts in the same cycle the assembly register empties.
- Latency: frame_start sampled at cycle 0 -> first mem_addr at cycle 1 -> bitstream_available high at cycle 3*STRIPE_COUNT+2.
- Handshake: bitstream_available stays high and bitstream stays stable until bitstream_read is sampled high. The word is then retired: available drops next cycle, unless a new word loads in that same cycle. bitstream_read while available=0 is ignored.
- Exactly LED_COUNT words are presented per frame. frame_done pulses in the cycle after the LED_COUNT-th read; busy falls in that same cycle.
- frame_start while busy: ignored, with no effect on counters. frame_start arriving in the same cycle as frame_done: ignored.

Optional Feature:
WS2812B_BRIGHTNESS_EN
- Defined: adds input port brightness[7:0]. Each captured byte is replaced by (byte*(brightness+1))>>8 before it enters the assembly register. brightness=255 passes bytes unchanged; brightness=0 outputs 0. brightness is sampled per byte at capture time. Latency is unchanged because the multiply is combinational in the capture path.
- Undefined: no port, bytes pass through raw.

Decomposition:
- Package ws2812b_pkg: BITS_PER_LED=24, BYTES_PER_LED=3, colour offset constants G_OFS=0 / R_OFS=1 / B_OFS=2, FSM state encoding.
- One sub-module, ws2812b_byte_scale (the brightness multiply), instantiated only under WS2812B_BRIGHTNESS_EN. Everything else stays in the top of this block.

Test Plan:
1. STRIPE_COUNT=2, LED_COUNT=3, BRAM[a]=a; frame_start at cycle 0, bitstream_read held high -> first word 48'h030405_000102 with available high at cycle 8; then 48'h090A0B_060708 and 48'h0F1011_0C0D0E; frame_done a single pulse; no gaps longer than one fetch.
2. Same setup, bitstream_read held low for 40 cycles -> word 0 stable and available high throughout; exactly one 6-address fetch burst occurs (prefetch of LED 1), then addresses freeze until the read.
3. frame_start re-pulsed at cycle 5 and again in the frame_done cycle -> both ignored; exactly 3 words delivered; busy low after frame_done.
4. reset asserted for one cycle while word 1 is available -> next cycle available=0, busy=0, mem_addr=BASE_ADDR; a new frame_start restarts at LED 0 word 48'h030405_000102.
5. BASE_ADDR=16383, ADDR_WIDTH=14 -> address sequence 16383, 0, 1, ... (wrap-around).
6. WS2812B_BRIGHTNESS_EN, brightness=127, BRAM byte 0xFF -> output byte 0x7F; brightness=0 -> 0x00; brightness=255 -> 0xFF.
